uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_gen.sv | 37 +++
 rtl/uart_tx.sv | 158 +++++++++++++++
 tb/tb_uart_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and default timing/width constants,
// common to the transmitter and receiver.
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT = 16;
  localparam int unsigned UART_WIDTH        = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and wraps, tick marks the terminal count.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter popping bytes from a registered-output FIFO.
// Define UART_TX_PARITY_EN to append an even-parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned WIDTH        = UART_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_re,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  uart_state_e      state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             busy_q;
  logic             baud_clear_s;
  logic             tick_s;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (baud_clear_s),
    .tick  (tick_s)
  );

  // Next-state, shift/index update and handshake outputs
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    baud_clear_s = 1'b0;
    fifo_re      = 1'b0;
    tx_done      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        baud_clear_s = 1'b1;
        // rst_n gate keeps the FIFO untouched while reset is still held
        if (!fifo_empty && rst_n) begin
          fifo_re = 1'b1;
          state_d = ST_POP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_POP: begin
        baud_clear_s = 1'b1;
        state_d      = ST_LOAD;
      end
      ST_LOAD: begin
        baud_clear_s = 1'b1;
        shift_d      = fifo_data;
        idx_d        = '0;
`ifdef UART_TX_PARITY_EN
        parity_d     = ^fifo_data;
`endif
        state_d      = ST_START;
      end
      ST_START: begin
        if (tick_s) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s && (idx_q == IDX_W'(WIDTH - 1))) begin
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end else if (tick_s) begin
          idx_d   = idx_q + IDX_W'(1);
          shift_d = shift_q >> 1;
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick_s) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (tick_s) begin
          tx_done = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        baud_clear_s = 1'b1;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // Line level for the upcoming state, so tx comes straight from a flop
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      busy_q   <= (state_d != ST_IDLE);
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: FIFO model plus a per-cycle expected-waveform queue.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int HMAX = 16384;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fifo_empty;
  logic [W-1:0] fifo_data;
  logic         fifo_re;
  logic         tx;
  logic         busy;
  logic         tx_done;

  uart_tx #(.CLKS_PER_BIT(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_re    (fifo_re),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  logic [W-1:0] fq[$];
  logic [2:0]   exp_q[$];
  logic         hist_tx [HMAX];
  logic         hist_busy [HMAX];
  int           pop_cyc[$];
  int           done_cyc[$];
  int           data_hold = 0;
  int           pushes = 0;
  int           tot_pops = 0;
  int           tot_dones = 0;
  int           re_hi_cnt = 0;
  int           tx_lo_cnt = 0;
  int           busy_cnt = 0;
  logic         re_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected per-cycle {tx, busy, tx_done} for one frame, starting the cycle after the pop
  task automatic push_frame(input logic [W-1:0] b);
    exp_q.push_back(3'b110);
    exp_q.push_back(3'b110);
    for (int k = 0; k < N; k++) exp_q.push_back(3'b010);
    for (int i = 0; i < W; i++)
      for (int k = 0; k < N; k++) exp_q.push_back({b[i], 2'b10});
`ifdef UART_TX_PARITY_EN
    for (int k = 0; k < N; k++) exp_q.push_back({^b, 2'b10});
`endif
    for (int k = 0; k < N; k++) exp_q.push_back((k == N - 1) ? 3'b111 : 3'b110);
  endtask

  task automatic push_byte(input logic [W-1:0] b);
    fq.push_back(b);
    fifo_empty = 1'b0;
    pushes++;
  endtask

  task automatic check_cycle();
    logic [2:0] e;
    logic       exp_re;
    cyc++;
    exp_re = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e = 3'b100;
      exp_re = rst_n && (fq.size() > 0);
    end
    chk("tx", 32'(tx), 32'(e[2]));
    chk("busy", 32'(busy), 32'(e[1]));
    chk("tx_done", 32'(tx_done), 32'(e[0]));
    chk("fifo_re", 32'(fifo_re), 32'(exp_re));
    chk("re_while_empty", 32'(fifo_re & fifo_empty), 32'd0);
    if (exp_re) push_frame(fq[0]);
    if (!rst_n) exp_q.delete();
    if (cyc < HMAX) begin
      hist_tx[cyc]   = tx;
      hist_busy[cyc] = busy;
    end
    if (fifo_re === 1'b1) begin pop_cyc.push_back(cyc); tot_pops++; re_hi_cnt++; end
    if (tx_done === 1'b1) begin done_cyc.push_back(cyc); tot_dones++; end
    if (tx !== 1'b1) tx_lo_cnt++;
    if (busy !== 1'b0) busy_cnt++;
    re_seen = (fifo_re === 1'b1);
  endtask

  // Registered-output FIFO: data valid for the two cycles after a pop, junk otherwise
  task automatic apply_edge();
    if (re_seen && fq.size() > 0) begin
      fifo_data = fq.pop_front();
      data_hold = 2;
    end else if (data_hold > 0) begin
      data_hold--;
    end
    if (data_hold == 0) fifo_data = W'($urandom);
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
      apply_edge();
    end
  endtask

  task automatic run_until_drained(input int budget);
    int i;
    i = 0;
    while ((exp_q.size() > 0 || fq.size() > 0) && i < budget) begin
      run_cycles(1);
      i++;
    end
    chk("drain_timeout", 32'(exp_q.size() > 0 || fq.size() > 0), 32'd0);
    run_cycles(2);
  endtask

  function automatic logic [W-1:0] decode(input int s);
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = hist_tx[s + N * (1 + i) + N / 2];
    return v;
  endfunction

  function automatic int count_level(input int s, input logic lvl);
    int c;
    c = 0;
    for (int k = 0; k < N; k++) if (hist_tx[s + k] === lvl) c++;
    return c;
  endfunction

  initial begin
    logic [10:0] a5_bits;
    int          s, d1, s2, c0, p0, i;

    rst_n      = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fifo_re", 32'(fifo_re), 32'd0);
    chk("rst_tx_done", 32'(tx_done), 32'd0);
    run_cycles(2);
    rst_n = 1'b1;
    run_cycles(3);

    // Single byte 0xA5
    pop_cyc.delete(); done_cyc.delete();
    push_byte(8'hA5);
    run_until_drained(200);
    chk("a5_pops", 32'(pop_cyc.size()), 32'd1);
    chk("a5_dones", 32'(done_cyc.size()), 32'd1);
`ifdef UART_TX_PARITY_EN
    a5_bits = 11'b10101001010;
`else
    a5_bits = 11'b01101001010;
`endif
    if (pop_cyc.size() > 0 && done_cyc.size() > 0) begin
      s = pop_cyc[0] + 3;
      for (int b = 0; b < 10 + P; b++) chk("a5_bit_hold", 32'(count_level(s + N * b, a5_bits[b])), 32'(N));
      chk("a5_frame_len", 32'(done_cyc[0] - s + 1), 32'(N * (10 + P)));
    end

    // FIFO empty for 200 cycles
    re_hi_cnt = 0; tx_lo_cnt = 0; busy_cnt = 0;
    run_cycles(200);
    chk("idle_re", 32'(re_hi_cnt), 32'd0);
    chk("idle_tx_low", 32'(tx_lo_cnt), 32'd0);
    chk("idle_busy", 32'(busy_cnt), 32'd0);

    // Back-to-back 0x01, 0x80
    pop_cyc.delete(); done_cyc.delete();
    push_byte(8'h01);
    push_byte(8'h80);
    run_until_drained(300);
    chk("b2b_pops", 32'(pop_cyc.size()), 32'd2);
    chk("b2b_dones", 32'(done_cyc.size()), 32'd2);
    if (pop_cyc.size() == 2 && done_cyc.size() > 0) begin
      d1 = done_cyc[0];
      s2 = d1 + 1;
      while (s2 < cyc && hist_tx[s2] !== 1'b0) s2++;
      chk("b2b_gap", 32'(s2 - d1 - 1), 32'd3);
      chk("b2b_byte0", 32'(decode(pop_cyc[0] + 3)), 32'h01);
      chk("b2b_byte1", 32'(decode(pop_cyc[1] + 3)), 32'h80);
    end

    // Reset during data bit 3 of 0xFF, 0x3C queued behind it
    pop_cyc.delete(); done_cyc.delete();
    push_byte(8'hFF);
    push_byte(8'h3C);
    p0 = tot_pops;
    i = 0;
    while (tot_pops == p0 && i < 50) begin run_cycles(1); i++; end
    chk("rst_pop_timeout", 32'(tot_pops == p0), 32'd0);
    c0 = cyc;
    while (cyc + 1 < c0 + 20) run_cycles(1);
    rst_n = 1'b0;
    run_cycles(1);
    rst_n = 1'b1;
    run_cycles(1);
    chk("midrst_tx", 32'(hist_tx[c0 + 21]), 32'd1);
    chk("midrst_busy", 32'(hist_busy[c0 + 21]), 32'd0);
    run_until_drained(300);
    chk("midrst_pops", 32'(pop_cyc.size()), 32'd2);
    chk("midrst_dones", 32'(done_cyc.size()), 32'd1);
    if (pop_cyc.size() == 2) chk("midrst_byte", 32'(decode(pop_cyc[1] + 3)), 32'h3C);

    // Slot after bit 7: parity when enabled, otherwise the stop bit
    pop_cyc.delete(); done_cyc.delete();
    push_byte(8'h07);
    push_byte(8'h03);
    run_until_drained(300);
    chk("par_pops", 32'(pop_cyc.size()), 32'd2);
    if (pop_cyc.size() == 2) begin
      chk("par_slot_07", 32'(hist_tx[pop_cyc[0] + 3 + N * 9 + N / 2]), 32'd1);
`ifdef UART_TX_PARITY_EN
      chk("par_slot_03", 32'(hist_tx[pop_cyc[1] + 3 + N * 9 + N / 2]), 32'd0);
`else
      chk("par_slot_03", 32'(hist_tx[pop_cyc[1] + 3 + N * 9 + N / 2]), 32'd1);
`endif
      if (done_cyc.size() == 2)
        chk("par_frame_len", 32'(done_cyc[1] - (pop_cyc[1] + 3) + 1), 32'(N * (10 + P)));
    end

    // Random bytes with random arrival gaps
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) != 0) push_byte(W'($urandom));
      run_cycles($urandom_range(1, 60));
    end
    run_until_drained(5000);

    chk("total_pops", 32'(tot_pops), 32'(pushes));
    chk("total_dones", 32'(tot_dones), 32'(pushes - 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
